dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Load/store unit in the MEM stage; the initiator side of the data-memory port.
- Converts pipeline byte/halfword/word load and store requests into word-aligned accesses on the data memory (combinational read, write on posedge clk with we).
- Sub-word stores use a read-modify-write sequence. Misaligned and out-of-range requests are trapped before any memory access.

Parameters:
- MEM_WORDS, 64, number of 32-bit words in data memory; word index >= MEM_WORDS is out of range.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- req_ready  output  1  unit can accept a request this cycle
- resp_valid  output  1  one-cycle pulse: request complete
- resp_rdata  output  32  load result, valid with resp_valid
- resp_err  output  1  with resp_valid: misaligned, illegal size or out of range
- mem_we  output  1  data memory write enable
- mem_a  output  32  data memory byte address, bits [1:0] always 0
- mem_wd  output  32  data memory write data
- mem_rd  input  32  data memory read data (combinational from mem_a)

Behaviour:
- Clock and reset:
  - Single clock clk; reset is synchronous, active-high.
  - Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, mem_we 0, mem_a 0, mem_wd 0.
- Byte lanes are little-endian: byte k occupies bits [8k+7:8k]; halfword h occupies bits [16h+15:16h].
- FSM states: IDLE, ACCESS, WRITE, ERR.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the request. Go to ERR if size=11, if (half and addr[0]) or (word and addr[1:0]!=0), or if addr[31:2] >= MEM_WORDS. Otherwise go to ACCESS.
- ACCESS (req_ready=0, mem_a={addr[31:2],2'b00}):
  - Load: extract the lane from mem_rd, sign- or zero-extend it, register it into resp_rdata. Next state IDLE; resp_valid=1 in the following cycle.
  - Word store: mem_we=1, mem_wd=wdata. Next state IDLE with resp_valid=1.
  - Sub-word store: merge wdata[7:0] or [15:0] into the mem_rd lane, register the merged word. Next state WRITE; mem_we=0 in ACCESS.
- WRITE (req_ready=0): mem_we=1, mem_wd=merged word, same mem_a. Next state IDLE with resp_valid=1.
- ERR (req_ready=0): mem_we=0. Next state IDLE with resp_valid=1, resp_err=1, resp_rdata=0.
- Latency, counted from the accept edge at cycle N (resp_valid is high in the cycle given):
  - Load and word store: resp_valid in N+2.
  - Sub-word store: resp_valid in N+3.
  - Error: resp_valid in N+2.
- resp_valid and resp_err are single-cycle pulses, coincident with the return to IDLE.
- A new request may be accepted in the same cycle resp_valid is high (back-to-back, 2-cycle throughput).
- mem_we is asserted only in ACCESS (word store) or WRITE, and never for loads or errors.
- mem_a, mem_wd and mem_we are combinational from registered state only, never from req_* inputs.
- Reset mid-operation (any state) returns to IDLE at that edge. mem_we is low from the next cycle, the pending write is dropped, and no resp_valid is produced.
- req_valid while req_ready=0 is ignored; the pipeline holds the request.
- req_signed is ignored for stores and for word loads.

Decomposition:
- Package dmem_lsu_pkg:
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state encoding.
- Sub-module dmem_lsu_lane (purely combinational), used by dmem_lsu:
  - Load extraction and extension from (word, addr[1:0], size, signed).
  - Store merge from (old word, wdata, addr[1:0], size).

Test Plan:
- Memory word 3 = 32'h8899AABB; load byte signed at addr 0x0D -> resp_valid at N+2, resp_rdata=32'hFFFFFFAA, resp_err=0, mem_we never high.
- Same word; load halfword unsigned at 0x0E -> resp_rdata=32'h00008899; load halfword signed -> 32'hFFFF8899.
- Store byte 32'h00000055 to 0x0D over 32'h8899AABB -> ACCESS with mem_we=0, WRITE with mem_we=1, mem_wd=32'h889955BB, mem_a=0x0C; resp_valid at N+3.
- Store word 32'hDEADBEEF to 0x10 -> mem_we=1 for exactly one cycle (N+1), word 4 = 32'hDEADBEEF; an immediately following word load of 0x10 accepted on the resp_valid cycle returns 32'hDEADBEEF.
- Error cases, each giving resp_err=1 with rdata 0 at N+2 and mem_we never high:
  - halfword load at 0x03
  - word store at 0x06
  - size=11
  - word load at 0x100 with MEM_WORDS=64
- Half store to 0x12: assert reset in the WRITE cycle -> no memory write occurs, no resp_valid, req_ready=1 next cycle, memory word 4 unchanged.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes, FSM states
// and the alignment rule used when a request is accepted.
package dmem_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WRITE  = 2'b10,
        ERR    = 2'b11
    } state_t;

    // True when the size code is illegal or the byte offset breaks natural alignment.
    function automatic logic size_fault(input logic [1:0] size, input logic [1:0] offset);
        logic fault;
        fault = 1'b0;
        case (size)
            SZ_BYTE: fault = 1'b0;
            SZ_HALF: fault = offset[0];
            SZ_WORD: fault = (offset != 2'b00);
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/dmem_lsu_lane.sv
// Byte-lane steering for the load/store unit: little-endian load extraction with
// optional sign extension, and the sub-word merge used by read-modify-write stores.
module dmem_lsu_lane
    import dmem_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] lane_mask;

    // Word accesses are always aligned, so the full mask with a zero shift
    // turns the merge into a plain replacement.
    always_comb begin
        shamt     = {offset, 3'b000};
        shifted   = word >> shamt;
        load_data = word;
        lane_mask = 32'hFFFF_FFFF;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
                lane_mask = 32'h0000_00FF << shamt;
            end
            SZ_HALF: begin
                load_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
                lane_mask = 32'h0000_FFFF << shamt;
            end
            default: ;
        endcase
        merged = (word & ~lane_mask) | ((wdata << shamt) & lane_mask);
    end

endmodule

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: turns byte/half/word requests into word-aligned
// data-memory accesses, with read-modify-write for sub-word stores and early trapping.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    state_t      state;
    state_t      state_next;

    logic        lat_we;
    logic        lat_signed;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] merged_q;

    logic [31:0] lane_load;
    logic [31:0] lane_merged;
    logic        req_bad;
    logic        accept;
    logic        mem_we_raw;

    assign accept = (state == IDLE) && req_valid;

    always_comb begin
        req_bad = size_fault(req_size, req_addr[1:0]);
        if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS)) begin
            req_bad = 1'b1;
        end
    end

    dmem_lsu_lane u_lane (
        .word      (mem_rd),
        .wdata     (lat_wdata),
        .offset    (lat_addr[1:0]),
        .size      (lat_size),
        .is_signed (lat_signed),
        .load_data (lane_load),
        .merged    (lane_merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Memory-side outputs depend only on the registered request, never on req_*.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_we_raw = 1'b0;
        mem_a      = 32'h0;
        mem_wd     = 32'h0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_bad ? ERR : ACCESS;
                end
            end
            ACCESS: begin
                mem_a = {lat_addr[31:2], 2'b00};
                if (lat_we && (lat_size == SZ_WORD)) begin
                    mem_we_raw = 1'b1;
                    mem_wd     = lat_wdata;
                    state_next = IDLE;
                end else if (lat_we) begin
                    state_next = WRITE;
                end else begin
                    state_next = IDLE;
                end
            end
            WRITE: begin
                mem_a      = {lat_addr[31:2], 2'b00};
                mem_we_raw = 1'b1;
                mem_wd     = merged_q;
                state_next = IDLE;
            end
            ERR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reset aborts an in-flight write at the very edge it is sampled.
    assign mem_we = mem_we_raw & ~reset;

    // Request latch and registered response; responses pulse for one cycle
    // on the return to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_we     <= 1'b0;
            lat_signed <= 1'b0;
            lat_size   <= SZ_BYTE;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            merged_q   <= 32'h0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            if (accept) begin
                lat_we     <= req_we;
                lat_signed <= req_signed;
                lat_size   <= req_size;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
            end
            case (state)
                ACCESS: begin
                    if (!lat_we) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= lane_load;
                    end else if (lat_size == SZ_WORD) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= 32'h0;
                    end else begin
                        merged_q <= lane_merged;
                    end
                end
                WRITE: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= 32'h0;
                end
                ERR: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b1;
                    resp_rdata <= 32'h0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: behavioural data memory plus a byte-array
// reference model, directed cases and a randomized load/store mix.
module tb_dmem_lsu;
    import dmem_lsu_pkg::*;

    localparam int MEM_WORDS = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_a, mem_wd, mem_rd;

    always #5 clk = ~clk;

    dmem_lsu #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    // Physical data memory with a preload port used only while the DUT is in reset.
    logic [31:0] mem [0:MEM_WORDS-1];
    logic        pl_we;
    logic [5:0]  pl_idx;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (mem_we && (mem_a[31:2] < 30'(MEM_WORDS))) mem[mem_a[7:2]] <= mem_wd;
        else if (pl_we) mem[pl_idx] <= pl_data;
    end

    always_comb mem_rd = (mem_a[31:2] < 30'(MEM_WORDS)) ? mem[mem_a[7:2]] : 32'h0;

    // Reference model: memory as a flat little-endian byte array.
    logic [7:0] bmem [0:4*MEM_WORDS-1];

    int pass_cnt = 0;
    int check_cnt = 0;

    int          obs_lat;
    logic [31:0] obs_rdata;
    logic        obs_err;
    logic        obs_ready;
    logic [7:0]  obs_we_mask;
    logic [31:0] obs_wd [0:7];
    logic [31:0] obs_a  [0:7];

    function automatic logic model_bad(input logic [1:0] size, input logic [31:0] addr);
        int nbytes;
        if (size == 2'b11) return 1'b1;
        nbytes = 1 << size;
        if ((addr % nbytes) != 0) return 1'b1;
        return (addr / 4) >= MEM_WORDS;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                               input logic [31:0] addr);
        longint v = 0;
        int nbytes = 1 << size;
        for (int i = 0; i < nbytes; i++) v += longint'(bmem[int'(addr) + i]) << (8 * i);
        if (sgn && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1)))
            v -= (longint'(1) << (8 * nbytes));
        return v[31:0];
    endfunction

    task automatic model_store(input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata);
        int nbytes = 1 << size;
        for (int i = 0; i < nbytes; i++) bmem[int'(addr) + i] = 8'((wdata >> (8 * i)) & 32'hFF);
    endtask

    function automatic logic [31:0] model_word(input int idx);
        return {bmem[4*idx+3], bmem[4*idx+2], bmem[4*idx+1], bmem[4*idx]};
    endfunction

    // Presents one request from a negedge and records what happens, cycle by cycle,
    // up to the response (cycle k after the accepting edge).
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        obs_ready   = req_ready;
        obs_lat     = 0;
        obs_rdata   = 32'h0;
        obs_err     = 1'b0;
        obs_we_mask = 8'h0;
        req_valid   = 1'b1;
        req_we      = we;
        req_size    = size;
        req_signed  = sgn;
        req_addr    = addr;
        req_wdata   = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            obs_we_mask[k] = mem_we;
            obs_wd[k] = mem_wd;
            obs_a[k]  = mem_a;
            if (resp_valid) begin
                obs_lat   = k;
                obs_rdata = resp_rdata;
                obs_err   = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        for (int i = 0; i < MEM_WORDS; i++) begin
            d = (i == 3) ? 32'h8899AABB : $urandom;
            pl_we = 1'b1; pl_idx = 6'(i); pl_data = d;
            for (int b = 0; b < 4; b++) bmem[4*i+b] = 8'((d >> (8 * b)) & 32'hFF);
            @(posedge clk);
            #1;
        end
        pl_we = 1'b0;
        @(negedge clk);
        check_cnt++;
        if ({req_ready, resp_valid, resp_err, mem_we} !== 4'b1000)
            $display("[TB] FAIL reset_flags: got ready/valid/err/we=%b required 1000",
                     {req_ready, resp_valid, resp_err, mem_we});
        else pass_cnt++;
        check_cnt++;
        if ({resp_rdata, mem_a, mem_wd} !== 96'h0)
            $display("[TB] FAIL reset_data: got rdata=%h a=%h wd=%h required all zero",
                     resp_rdata, mem_a, mem_wd);
        else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
        check_cnt++;
        if ({req_ready, resp_valid, mem_we} !== 3'b100)
            $display("[TB] FAIL post_reset_idle: got ready/valid/we=%b required 100",
                     {req_ready, resp_valid, mem_we});
        else pass_cnt++;
    endtask

    task automatic test_load_lanes();
        logic [31:0] addrs [3] = '{32'h0D, 32'h0E, 32'h0E};
        logic [1:0]  sizes [3] = '{SZ_BYTE, SZ_HALF, SZ_HALF};
        logic        sgns  [3] = '{1'b1, 1'b0, 1'b1};
        logic [31:0] exps  [3] = '{32'hFFFFFFAA, 32'h00008899, 32'hFFFF8899};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, sizes[i], sgns[i], addrs[i], $urandom);
            check_cnt++;
            if (obs_lat != 2) $display("[TB] FAIL load%0d_latency: got %0d required 2", i, obs_lat);
            else pass_cnt++;
            check_cnt++;
            if ({obs_err, obs_rdata} !== {1'b0, exps[i]})
                $display("[TB] FAIL load%0d_data: got err=%b rdata=%h required err=0 rdata=%h",
                         i, obs_err, obs_rdata, exps[i]);
            else pass_cnt++;
            check_cnt++;
            if (obs_we_mask !== 8'h0)
                $display("[TB] FAIL load%0d_no_write: got we mask %b required 0", i, obs_we_mask);
            else pass_cnt++;
        end
    endtask

    task automatic test_store_byte();
        applyStimulus(1'b1, SZ_BYTE, 1'b0, 32'h0D, 32'h00000055);
        model_store(SZ_BYTE, 32'h0D, 32'h00000055);
        check_cnt++;
        if (obs_lat != 3) $display("[TB] FAIL sb_latency: got %0d required 3", obs_lat);
        else pass_cnt++;
        check_cnt++;
        if (obs_we_mask !== 8'b0000_0100)
            $display("[TB] FAIL sb_we_cycles: got mask %b required 00000100", obs_we_mask);
        else pass_cnt++;
        check_cnt++;
        if ({obs_a[2], obs_wd[2]} !== {32'h0000000C, 32'h889955BB})
            $display("[TB] FAIL sb_write_beat: got a=%h wd=%h required a=0000000c wd=889955bb",
                     obs_a[2], obs_wd[2]);
        else pass_cnt++;
        check_cnt++;
        if (mem[3] !== 32'h889955BB)
            $display("[TB] FAIL sb_mem_word3: got %h required 889955bb", mem[3]);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
        model_store(SZ_WORD, 32'h10, 32'hDEADBEEF);
        check_cnt++;
        if (obs_lat != 2) $display("[TB] FAIL sw_latency: got %0d required 2", obs_lat);
        else pass_cnt++;
        check_cnt++;
        if (obs_we_mask !== 8'b0000_0010 || obs_wd[1] !== 32'hDEADBEEF || obs_a[1] !== 32'h10)
            $display("[TB] FAIL sw_write_beat: got mask=%b wd=%h a=%h required 00000010/deadbeef/00000010",
                     obs_we_mask, obs_wd[1], obs_a[1]);
        else pass_cnt++;
        applyStimulus(1'b0, SZ_WORD, 1'b1, 32'h10, $urandom);
        check_cnt++;
        if (obs_ready !== 1'b1) $display("[TB] FAIL b2b_ready: got %b required 1", obs_ready);
        else pass_cnt++;
        check_cnt++;
        if (obs_lat != 2 || obs_rdata !== 32'hDEADBEEF)
            $display("[TB] FAIL b2b_load: got lat=%0d rdata=%h required lat=2 rdata=deadbeef",
                     obs_lat, obs_rdata);
        else pass_cnt++;
    endtask

    task automatic test_errors();
        logic        wes   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  sizes [4] = '{SZ_HALF, SZ_WORD, SZ_ILL, SZ_WORD};
        logic [31:0] addrs [4] = '{32'h03, 32'h06, 32'h20, 32'h100};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(wes[i], sizes[i], 1'b1, addrs[i], $urandom);
            check_cnt++;
            if (obs_lat != 2) $display("[TB] FAIL err%0d_latency: got %0d required 2", i, obs_lat);
            else pass_cnt++;
            check_cnt++;
            if ({obs_err, obs_rdata} !== {1'b1, 32'h0})
                $display("[TB] FAIL err%0d_resp: got err=%b rdata=%h required err=1 rdata=0",
                         i, obs_err, obs_rdata);
            else pass_cnt++;
            check_cnt++;
            if (obs_we_mask !== 8'h0)
                $display("[TB] FAIL err%0d_no_write: got we mask %b required 0", i, obs_we_mask);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_write();
        int events = 0;
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_HALF; req_signed = 1'b0;
        req_addr = 32'h12; req_wdata = 32'h1234CAFE;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_cnt++;
        if (mem_we !== 1'b1) $display("[TB] FAIL rst_reached_write: got mem_we=%b required 1", mem_we);
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_cnt++;
        if ({req_ready, resp_valid, mem_we} !== 3'b100)
            $display("[TB] FAIL rst_abort_state: got ready/valid/we=%b required 100",
                     {req_ready, resp_valid, mem_we});
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (resp_valid || mem_we) events++;
        end
        check_cnt++;
        if (events != 0) $display("[TB] FAIL rst_quiet: got %0d stray cycles required 0", events);
        else pass_cnt++;
        check_cnt++;
        if (mem[4] !== model_word(4))
            $display("[TB] FAIL rst_mem_word4: got %h required %h", mem[4], model_word(4));
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic        we, sgn, bad;
        logic [1:0]  size;
        logic [31:0] addr, wdata, exp_rdata;
        int          exp_lat;
        for (int n = 0; n < 150; n++) begin
            we    = 1'($urandom_range(0, 1));
            sgn   = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            wdata = $urandom;
            addr  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4*MEM_WORDS-1));
            if (size != 2'b11 && $urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 1);
            bad       = model_bad(size, addr);
            exp_lat   = (!bad && we && size != SZ_WORD) ? 3 : 2;
            exp_rdata = (bad || we) ? 32'h0 : model_load(size, sgn, addr);
            applyStimulus(we, size, sgn, addr, wdata);
            if (!bad && we) model_store(size, addr, wdata);
            check_cnt++;
            if (obs_lat != exp_lat || obs_ready !== 1'b1 || obs_err !== bad)
                $display("[TB] FAIL rnd%0d_handshake: got lat=%0d ready=%b err=%b required lat=%0d ready=1 err=%b",
                         n, obs_lat, obs_ready, obs_err, exp_lat, bad);
            else pass_cnt++;
            check_cnt++;
            if ($countones(obs_we_mask) != ((!bad && we) ? 1 : 0))
                $display("[TB] FAIL rnd%0d_we_count: got mask %b required %0d write beats",
                         n, obs_we_mask, (!bad && we) ? 1 : 0);
            else pass_cnt++;
            if (!we || bad) begin
                check_cnt++;
                if (obs_rdata !== exp_rdata)
                    $display("[TB] FAIL rnd%0d_rdata: got %h required %h (size=%0d addr=%h signed=%b)",
                             n, obs_rdata, exp_rdata, size, addr, sgn);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_memory_contents();
        for (int i = 0; i < MEM_WORDS; i++) begin
            check_cnt++;
            if (mem[i] !== model_word(i))
                $display("[TB] FAIL mem_word%0d: got %h required %h", i, mem[i], model_word(i));
            else pass_cnt++;
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = SZ_BYTE; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        pl_we = 1'b0; pl_idx = 6'h0; pl_data = 32'h0;
        test_reset();
        test_load_lanes();
        test_store_byte();
        test_back_to_back();
        test_errors();
        test_reset_mid_write();
        test_random();
        test_memory_contents();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
